seg_scan_driver: RTL
====================

# seg_scan_driver

Parametrised multiplexed seven-segment display driver, successor to the fixed 8-digit scanner. It sits between the game/control logic and the board's digit-select and segment pins. It adds the following on top of plain scanning:
- a single-clock-domain scan enable in place of a derived clock,
- a frame-synchronous shadow buffer, so displayed text never tears mid-frame,
- a per-digit decimal point, a per-digit blink mask and an anti-ghosting blank interval.

## Interface
- DIGITS, 8: number of multiplexed digits (2..16).
- SCAN_DIV, 31250: clk cycles per digit slot (≥ 4).
- BLANK_CYCLES, 0: cycles at the start of each slot with all digits off (< SCAN_DIV).
- BLINK_FRAMES, 64: scan frames per blink half-period (≥ 1).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = display on; 0 = outputs forced dark, counters keep running.
- load  in  1  one-cycle strobe; captures disp_data, dp_in and blink_mask into the pending register.
- disp_data  in  5*DIGITS  glyph codes; field [5*DIGITS-1 -: 5] is digit 0 (leftmost).
- dp_in  in  DIGITS  decimal point per digit; bit DIGITS-1 is digit 0.
- blink_mask  in  DIGITS  1 = digit blinks; same bit order as dp_in.
- bit_sel  out  DIGITS  one-hot, active-high digit select; digit 0 drives bit DIGITS-1.
- seg_out  out  8  segments, active-high: [7]=top, [6]=upper-right, [5]=lower-right, [4]=bottom, [3]=lower-left, [2]=upper-left, [1]=middle, [0]=dp.
- frame_done  out  1  one-cycle pulse at each frame wrap.

## Operation
- Glyph code map, standard 5-bit team code:
  - 0–15: hex digits 0–F.
  - 16–30: H i j L n o P M r t u v y ? g.
  - 31: blank.
  - Examples: 0→8'hFC, 1→8'h60, 8→8'hFE, 10 (A)→8'hEE, 31→8'h00.
  - Glyph bit 0 is always 0; seg_out[0] is the dp bit of the active digit.
- Registers:
  - slot counter: 0..SCAN_DIV-1.
  - digit index: 0..DIGITS-1.
  - blink frame counter: 0..BLINK_FRAMES-1.
  - blink_on flag.
  - pending register plus pending_valid flag.
  - active (displayed) register.
- Slot counter wraps to 0 at SCAN_DIV-1 and advances the digit index.
- Digit index wraps at DIGITS-1 → 0. That wrap is the frame boundary:
  - frame_done pulses.
  - If pending_valid, pending copies into active and pending_valid clears.
  - Blink frame counter advances; at its wrap, blink_on toggles.
- load sets pending_valid and overwrites pending; the last load before a boundary wins.
- load in the same cycle as a boundary:
  - The boundary commits the pending contents held before that cycle.
  - The new value stays pending for the next frame.
- Digit d is lit when all hold: enable=1, slot counter ≥ BLANK_CYCLES, and NOT (blink_mask_active[d] AND blink_on=0).
- When digit d is lit: bit_sel has only digit d's bit set, and seg_out = glyph | dp.
- When digit d is not lit: bit_sel=0 and seg_out=8'h00.

## Timing
- Reset, asynchronous, takes effect immediately:
  - bit_sel=0, seg_out=0, frame_done=0.
  - All counters 0; blink_on=1.
  - Active register: all glyphs 31, dp=0, blink=0. Pending cleared, pending_valid=0.
- Reset asserted mid-frame discards any pending load. After release, scanning restarts at digit 0, slot 0.
- bit_sel, seg_out and frame_done are registered and follow internal state with exactly 1 clk of latency.
- A load becomes visible at most one frame (DIGITS*SCAN_DIV cycles) plus 1 cycle after the strobe.
- frame_done is high for exactly 1 cycle per DIGITS*SCAN_DIV cycles.
- Blink period is 2*BLINK_FRAMES frames with a 50% duty cycle.
- enable only gates the outputs, with 1-cycle latency. Scan phase is preserved across enable toggles.

## Test plan
- Reset, with DIGITS=8, SCAN_DIV=4, BLANK_CYCLES=0:
  - During reset: bit_sel=0, seg_out=0.
  - After release: digits 0..7 scan with glyph 31 (seg_out=00).
  - frame_done pulses every 32 cycles.
- Static pattern: load disp_data=0,1,…,7 with dp on digit 3.
  - After the next frame_done: bit_sel=8'h80 with seg_out=FC, then 8'h40 with 60.
  - Digit 3 shows F2|01=F3.
- No tearing: issue load mid-frame with all 8s.
  - The remaining digits of the current frame keep the old glyphs.
  - From the next frame, every digit shows FE.
- Load coincident with frame_done: the previous pending value is displayed first; the new value appears one frame later.
- Blink and blank, with BLINK_FRAMES=2, BLANK_CYCLES=1, blink_mask=8'h01:
  - Digit 7 is dark for 2 frames, then lit for 2 frames, repeating.
  - Every slot starts with 1 cycle of bit_sel=0.
- Enable and async reset:
  - enable=0 forces outputs dark while frame_done stays periodic.
  - rst_n pulsed mid-frame returns all outputs to 0 within the same cycle and drops the pending load.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner. Glyph/dp/blink text is double-buffered and swapped
// only at frame boundaries; outputs are registered one cycle behind the scan state.
module seg_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 31250,
  parameter int BLANK_CYCLES = 0,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [5*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [DIGITS-1:0]     bit_sel,
  output logic [7:0]            seg_out,
  output logic                  frame_done
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SW-1:0]       slot_cnt_reg;
  logic [DW-1:0]       digit_idx_reg;
  logic [BW-1:0]       blink_cnt_reg;
  logic                blink_on_reg;
  logic [5*DIGITS-1:0] pend_data_reg, act_data_reg;
  logic [DIGITS-1:0]   pend_dp_reg, pend_blink_reg, act_dp_reg, act_blink_reg;
  logic                pend_valid_reg;
  logic [DIGITS-1:0]   bit_sel_reg, bit_sel_next;
  logic [7:0]          seg_out_reg, seg_out_next;
  logic                frame_done_reg;

  logic slot_wrap, frame_wrap, in_blank, digit_lit;
  logic [4:0] glyph_arr [DIGITS];
  logic       dp_arr    [DIGITS];
  logic       blink_arr [DIGITS];

  function automatic logic [7:0] glyph_lut(input logic [4:0] code);
    case (code)
      5'd0:  return 8'hFC;  5'd1:  return 8'h60;  5'd2:  return 8'hDA;  5'd3:  return 8'hF2;
      5'd4:  return 8'h66;  5'd5:  return 8'hB6;  5'd6:  return 8'hBE;  5'd7:  return 8'hE0;
      5'd8:  return 8'hFE;  5'd9:  return 8'hF6;  5'd10: return 8'hEE;  5'd11: return 8'h3E;
      5'd12: return 8'h9C;  5'd13: return 8'h7A;  5'd14: return 8'h9E;  5'd15: return 8'h8E;
      5'd16: return 8'h6E;  5'd17: return 8'h20;  5'd18: return 8'h70;  5'd19: return 8'h1C;
      5'd20: return 8'h2A;  5'd21: return 8'h3A;  5'd22: return 8'hCE;  5'd23: return 8'hEC;
      5'd24: return 8'h0A;  5'd25: return 8'h1E;  5'd26: return 8'h38;  5'd27: return 8'h7C;
      5'd28: return 8'h76;  5'd29: return 8'hCA;  5'd30: return 8'hF6;
      default: return 8'h00;
    endcase
  endfunction

  // Digit 0 occupies the most-significant field of every packed vector.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
      assign glyph_arr[gi] = act_data_reg[5*(DIGITS-gi)-1 -: 5];
      assign dp_arr[gi]    = act_dp_reg[DIGITS-1-gi];
      assign blink_arr[gi] = act_blink_reg[DIGITS-1-gi];
    end
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = slot_cnt_reg < SW'(BLANK_CYCLES);
    end
  endgenerate

  assign slot_wrap  = slot_cnt_reg == SW'(SCAN_DIV-1);
  assign frame_wrap = slot_wrap && (digit_idx_reg == DW'(DIGITS-1));
  assign digit_lit  = enable && !in_blank && !(blink_arr[digit_idx_reg] && !blink_on_reg);

  always_comb begin
    bit_sel_next = '0;
    seg_out_next = '0;
    if (digit_lit) begin
      bit_sel_next = DIGITS'(1) << (DW'(DIGITS-1) - digit_idx_reg);
      seg_out_next = glyph_lut(glyph_arr[digit_idx_reg]) | {7'b0, dp_arr[digit_idx_reg]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_reg   <= '0;
      digit_idx_reg  <= '0;
      blink_cnt_reg  <= '0;
      blink_on_reg   <= 1'b1;
      pend_data_reg  <= '0;
      pend_dp_reg    <= '0;
      pend_blink_reg <= '0;
      pend_valid_reg <= 1'b0;
      act_data_reg   <= '1;
      act_dp_reg     <= '0;
      act_blink_reg  <= '0;
    end else begin
      slot_cnt_reg <= slot_wrap ? '0 : slot_cnt_reg + 1'b1;
      if (slot_wrap) digit_idx_reg <= frame_wrap ? '0 : digit_idx_reg + 1'b1;
      if (frame_wrap) begin
        if (blink_cnt_reg == BW'(BLINK_FRAMES-1)) begin
          blink_cnt_reg <= '0;
          blink_on_reg  <= ~blink_on_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
        if (pend_valid_reg) begin
          act_data_reg  <= pend_data_reg;
          act_dp_reg    <= pend_dp_reg;
          act_blink_reg <= pend_blink_reg;
        end
      end
      // A load on the boundary cycle is held over: the commit above uses the old pending value.
      if (load) begin
        pend_data_reg  <= disp_data;
        pend_dp_reg    <= dp_in;
        pend_blink_reg <= blink_mask;
        pend_valid_reg <= 1'b1;
      end else if (frame_wrap) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_sel_reg    <= '0;
      seg_out_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      bit_sel_reg    <= bit_sel_next;
      seg_out_reg    <= seg_out_next;
      frame_done_reg <= frame_wrap;
    end
  end

  assign bit_sel    = bit_sel_reg;
  assign seg_out    = seg_out_reg;
  assign frame_done = frame_done_reg;

endmodule
